// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between an
// instruction-fetch port (I) and a load/store port (D); one transaction per 4 cycles.
module mem_port_arbiter #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [31:0]   i_addr,
  output logic [31:0]   i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_wmask,
  output logic [31:0]   d_rdata,
  output logic          d_ack,
  output logic          m_en,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  output logic [3:0]    m_wmask,
  input  logic [31:0]   m_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          rr_q, rr_d;
  logic          m_en_q, m_en_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [31:0]   m_wdata_q, m_wdata_d;
  logic [3:0]    m_wmask_q, m_wmask_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          grant_port;

  // Byte-offset and out-of-range address bits are deliberately discarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    m_en_d     = 1'b0;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_wmask_d  = m_wmask_q;
    i_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_port = (i_req && d_req) ? rr_q : d_req;

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          owner_d = grant_port;
          m_en_d  = 1'b1;
          state_d = S_ACCESS;
          if (grant_port == PORT_D) begin
            m_addr_d  = d_addr[AW+1:2];
            m_wdata_d = d_wdata;
            m_wmask_d = d_wmask;
          end else begin
            m_addr_d  = i_addr[AW+1:2];
            m_wdata_d = '0;
            m_wmask_d = '0;
          end
        end
      end
      S_ACCESS: state_d = S_WAIT;
      S_WAIT: begin
        // RAM data from the ACCESS cycle is present now; stores leave rdata alone.
        if (owner_q == PORT_D) begin
          d_ack_d = 1'b1;
          if (m_wmask_q == 4'b0000) d_rdata_d = m_rdata;
        end else begin
          i_ack_d   = 1'b1;
          i_rdata_d = m_rdata;
        end
        rr_d    = ~owner_q;
        state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      owner_q   <= PORT_I;
      rr_q      <= PORT_I;
      m_en_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wmask_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      m_en_q    <= m_en_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wmask_q <= m_wmask_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign m_en    = m_en_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wmask = m_wmask_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expected responses from a
// word-array memory model, a negedge monitor pops and compares on every ack.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW    = 8;
  localparam int WORDS = 256;

  logic          clk;
  logic          reset;
  logic          i_req, d_req, i_ack, d_ack, m_en, busy;
  logic [31:0]   i_addr, d_addr, d_wdata, i_rdata, d_rdata, m_wdata, m_rdata;
  logic [3:0]    d_wmask, m_wmask;
  logic [AW-1:0] m_addr;

  mem_port_arbiter #(.AW(AW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_rdata(m_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  waddr;
    logic [3:0]  mask;
  } exp_t;

  logic [31:0] ram     [WORDS];
  logic [31:0] ref_mem [WORDS];
  logic        load_ram = 1'b0;
  exp_t        i_q[$];
  exp_t        d_q[$];
  bit          gl_is_d[$];
  int          gl_cyc[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;

  // Synchronous RAM seen by the DUT
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_ram) begin
      for (int w = 0; w < WORDS; w++) ram[w] <= ref_mem[w];
    end else if (m_en) begin
      for (int b = 0; b < 4; b++)
        if (m_wmask[b]) ram[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
      m_rdata <= ram[m_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor
  int          en_count = 0;
  int          en_cyc = 0;
  logic [7:0]  en_addr = '0;
  logic [3:0]  en_mask = '0;
  logic [31:0] en_wdata = '0;
  logic [31:0] i_hold = '0;
  logic [31:0] d_hold = '0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!reset) begin
      i_hold   = '0;
      d_hold   = '0;
      en_count = 0;
    end else begin
      if (m_en) begin
        en_count++;
        en_addr  = m_addr;
        en_mask  = m_wmask;
        en_wdata = m_wdata;
        en_cyc   = cyc;
      end
      if (i_ack) begin
        if (i_q.size() == 0) fail("i_ack_unexpected");
        else begin
          mon_e = i_q.pop_front();
          check("i_rdata", i_rdata, mon_e.data);
          check("i_m_addr", 32'(en_addr), 32'(mon_e.waddr));
          check("i_m_wmask", 32'(en_mask), 32'h0);
          check("i_m_en_once", en_count, 1);
          check("i_ack_after_m_en", cyc - en_cyc, 2);
          check("i_d_ack_excl", 32'(d_ack), 32'h0);
          check("i_d_rdata_held", d_rdata, d_hold);
          i_hold = mon_e.data;
          $display("txn I  waddr=%0d rdata=%h cycle=%0d", mon_e.waddr, i_rdata, cyc);
          gl_is_d.push_back(1'b0);
          gl_cyc.push_back(cyc);
        end
        en_count = 0;
      end
      if (d_ack) begin
        if (d_q.size() == 0) fail("d_ack_unexpected");
        else begin
          mon_e = d_q.pop_front();
          check("d_m_addr", 32'(en_addr), 32'(mon_e.waddr));
          check("d_m_wmask", 32'(en_mask), 32'(mon_e.mask));
          check("d_m_en_once", en_count, 1);
          check("d_ack_after_m_en", cyc - en_cyc, 2);
          check("d_i_ack_excl", 32'(i_ack), 32'h0);
          check("d_i_rdata_held", i_rdata, i_hold);
          if (mon_e.mask == 4'b0000) begin
            check("d_load_rdata", d_rdata, mon_e.data);
            d_hold = mon_e.data;
          end else begin
            check("d_store_wdata", en_wdata, mon_e.data);
            check("d_store_rdata_held", d_rdata, d_hold);
          end
          $display("txn D  waddr=%0d mask=%b data=%h cycle=%0d", mon_e.waddr, mon_e.mask, mon_e.data, cyc);
          gl_is_d.push_back(1'b1);
          gl_cyc.push_back(cyc);
        end
        en_count = 0;
      end
    end
  end

  function automatic logic [31:0] rand_addr(input int lo, input int hi);
    return ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(hi, lo)) << 2) | 32'($urandom_range(3, 0));
  endfunction

  // Drivers are entered and left just after a rising edge.
  task automatic do_i(input logic [31:0] addr, input int exp_lat);
    exp_t e;
    int   word, lat;
    bit   done;
    word    = int'((addr >> 2) % WORDS);
    e.data  = ref_mem[word];
    e.waddr = 8'(word);
    e.mask  = 4'b0000;
    i_q.push_back(e);
    i_addr = addr;
    i_req  = 1'b1;
    done   = 1'b0;
    lat    = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (i_ack) begin
        done = 1'b1;
        lat  = k;
      end
    end
    if (!done) fail("i_ack_timeout");
    else if (exp_lat > 0) check("i_latency", lat, exp_lat);
    @(posedge clk);
    #1;
    i_req  = 1'b0;
    i_addr = $urandom;
  endtask

  task automatic do_d(input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] mask, input int exp_lat);
    exp_t e;
    int   word, lat;
    bit   done;
    word    = int'((addr >> 2) % WORDS);
    e.waddr = 8'(word);
    e.mask  = mask;
    if (mask == 4'b0000) e.data = ref_mem[word];
    else begin
      e.data = wdata;
      for (int b = 0; b < 4; b++)
        if (mask[b]) ref_mem[word][8*b +: 8] = wdata[8*b +: 8];
    end
    d_q.push_back(e);
    d_addr  = addr;
    d_wdata = wdata;
    d_wmask = mask;
    d_req   = 1'b1;
    done    = 1'b0;
    lat     = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (d_ack) begin
        done = 1'b1;
        lat  = k;
      end
    end
    if (!done) fail("d_ack_timeout");
    else if (exp_lat > 0) check("d_latency", lat, exp_lat);
    @(posedge clk);
    #1;
    d_req   = 1'b0;
    d_addr  = $urandom;
    d_wdata = $urandom;
    d_wmask = 4'($urandom);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    for (int w = 0; w < WORDS; w++) ref_mem[w] = $urandom;
    ref_mem[2] = 32'hDEADBEEF;
    ref_mem[4] = 32'hAABBCCDD;
    i_req = 1'b0; d_req = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    reset = 1'b0;
    load_ram = 1'b1;
    @(posedge clk);
    #1;
    load_ram = 1'b0;
    @(negedge clk);
    check("rst_m_en", 32'(m_en), 0);
    check("rst_m_addr", 32'(m_addr), 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_m_wmask", 32'(m_wmask), 0);
    check("rst_acks", 32'({i_ack, d_ack}), 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed single-port transactions
    do_i(32'h0000_0008, 3);
    do_d(32'h0000_0010, 32'h1122_3344, 4'b0011, 3);
    do_d(32'h0000_0010, 32'h0, 4'b0000, 3);
    do_d(32'h0000_0400, 32'h0, 4'b0000, 3);

    // Both ports held busy for eight transactions
    gl_is_d.delete();
    gl_cyc.delete();
    fork
      repeat (4) do_i(rand_addr(0, 127), 0);
      repeat (4) do_d(rand_addr(128, 255), $urandom, 4'($urandom_range(1, 0) * $urandom_range(15, 1)), 0);
    join
    if (gl_is_d.size() != 8) fail("fair_count");
    else begin
      for (int k = 0; k < 8; k++) begin
        check("fair_order", 32'(gl_is_d[k]), 32'(k % 2));
        if (k > 0) check("fair_spacing", gl_cyc[k] - gl_cyc[k-1], 4);
      end
    end

    // After an I then a D-only transaction, contention must go to I
    do_i(rand_addr(0, 127), 3);
    do_d(rand_addr(128, 255), 32'h0, 4'b0000, 3);
    gl_is_d.delete();
    gl_cyc.delete();
    fork
      do_i(rand_addr(0, 127), 0);
      do_d(rand_addr(128, 255), $urandom, 4'b1000, 0);
    join
    if (gl_is_d.size() != 2) fail("rr_after_d_count");
    else check("rr_after_d_first", 32'(gl_is_d[0]), 32'h0);

    // Reset asserted during WAIT of a fetch
    i_addr = 32'h0000_0008;
    i_req  = 1'b1;
    got    = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (m_en) got = 1'b1;
    end
    if (!got) fail("rst_test_m_en_timeout");
    @(posedge clk);
    #1;
    check("wait_busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    check("mid_rst_m_en", 32'(m_en), 0);
    check("mid_rst_m_addr", 32'(m_addr), 0);
    check("mid_rst_m_wmask", 32'(m_wmask), 0);
    check("mid_rst_acks", 32'({i_ack, d_ack}), 0);
    check("mid_rst_i_rdata", i_rdata, 0);
    check("mid_rst_d_rdata", d_rdata, 0);
    check("mid_rst_busy", 32'(busy), 0);
    i_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    do_i(32'h0000_0008, 3);

    // Randomised concurrent traffic; I reads low half, D owns upper half
    fork
      for (int n = 0; n < 25; n++) begin
        do_i(rand_addr(0, 127), 0);
        repeat ($urandom_range(3, 0)) @(posedge clk);
      end
      for (int n = 0; n < 25; n++) begin
        do_d(rand_addr(128, 255), $urandom,
             ($urandom_range(1, 0) == 0) ? 4'b0000 : 4'($urandom_range(15, 1)), 0);
        repeat ($urandom_range(3, 0)) @(posedge clk);
      end
    join
    repeat (6) @(posedge clk);
    check("i_q_drained", i_q.size(), 0);
    check("d_q_drained", d_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
